regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Sequences the single write port of the 32x32 general-purpose register file.
- Sits between the two writeback sources (ALU writeback = requester 0, load/store writeback = requester 1) and the regfile write port (write, write_addr, write_data).
- After reset, sweeps zeros into every register.
- Then shares the write port between the requesters with round-robin arbitration over a valid/ready handshake.
- Write-port outputs are registered.

Parameters:
- DW, 32, data width (matches regfile).
- AW, 5, regfile address width; 2**AW registers.
- INIT_SWEEP, 1, 1 = zero-sweep all registers after reset; 0 = enter RUN directly.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  AW  ALU destination register.
- req0_data  in  DW  ALU result.
- req0_ready  out  1  ALU request accepted this cycle (combinational).
- req1_valid  in  1  LSU writeback request.
- req1_addr  in  AW  LSU destination register.
- req1_data  in  DW  load data.
- req1_ready  out  1  LSU request accepted this cycle (combinational).
- write  out  1  regfile write enable (registered).
- write_addr  out  AW  regfile write address (registered).
- write_data  out  DW  regfile write data (registered).
- init_done  out  1  high once in RUN.
- conflict_cnt  out  16  count of cycles where both requesters were valid.

Behaviour:
Reset:
- One clock domain; reset asynchronous, active-low on rst_n.
- While rst_n=0: write=0, write_addr=0, write_data=0, init_done=0, conflict_cnt=0, sweep counter=0, last_grant=1 (so req0 wins the first contention).
- State after reset is INIT if INIT_SWEEP=1, else RUN.
- Reset asserted mid-sweep or mid-transfer aborts immediately. A request accepted in the cycle before reset is lost.

FSM states:
- INIT: each cycle, register write=1, write_addr=cnt, write_data=0, then cnt++. Both readys=0.
  - When cnt=2**AW-1 is issued, go to RUN next cycle.
  - Sweep occupies exactly 2**AW cycles; write pulses appear on the 2**AW cycles following reset release.
- RUN: init_done=1. Arbitration:
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester != last_grant. last_grant updates on every grant.
  - reqN_ready = (state==RUN) && grant==N. Ready is combinational from valid; it never depends on the other requester's ready.
  - Transfer occurs when valid && ready. On the next rising edge: write=1, write_addr/write_data = granted requester's addr/data.
  - No grant in a cycle: write=0 next cycle; write_addr/write_data hold their last values.
- Latency: accept at edge t, write high during cycle t+1 for exactly one cycle. Throughput is one write per cycle.
- A requester not granted keeps valid and payload stable until ready. The block does not buffer the loser.
- Both requesters targeting the same address in the same cycle: serialized by round-robin. The later grant overwrites the earlier one, in grant order.
- conflict_cnt increments on every RUN cycle with req0_valid && req1_valid. It saturates at 16'hFFFF and does not wrap.
- Requests valid during INIT are held off (ready=0). They are granted starting in the first RUN cycle.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: requests with addr==0 are still accepted (ready per arbitration, last_grant updated), but write stays 0 for that slot. Register 0 stays 0 after the sweep.
- Not defined: address 0 is written like any other register.

Test Plan:
- Reset release, INIT_SWEEP=1, no requests -> 32 consecutive write pulses, addr 0..31, data 0; init_done rises the cycle after addr 31 issues; readys 0 throughout.
- RUN, only req0_valid, addr=5, data=32'hDEAD_BEEF -> req0_ready=1 same cycle; next cycle write=1, addr=5, data=32'hDEADBEEF; following cycle write=0.
- Both valid 4 cycles, req0 addr=3/data=A, req1 addr=4/data=B -> grants 0,1,0,1; write pulses addr 3,4,3,4 back-to-back; conflict_cnt=4.
- Both valid same addr=7, req0 data=1, req1 data=2, req1 drops after grant -> writes to addr 7 in order data 1 then 2; final regfile r7=2.
- rst_n pulsed low mid-sweep at cnt=10 -> outputs 0 asynchronously; sweep restarts at addr 0 after release.
- REGFILE_ZERO_REG_EN defined, req1 addr=0, data=32'h1234 -> req1_ready=1; write stays 0 next cycle; a subsequent req0 addr=1 issues normally.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port sequencer: zero sweep after reset, then round-robin
// arbitration between ALU and LSU writeback. Optional: REGFILE_ZERO_REG_EN keeps r0 at zero.
module regfile_wb_arbiter #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5,
    parameter bit          INIT_SWEEP = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          write,
    output logic [AW-1:0] write_addr,
    output logic [DW-1:0] write_data,
    output logic          init_done,
    output logic [15:0]   conflict_cnt
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [AW-1:0] CNT_LAST  = {AW{1'b1}};
    localparam logic          ST_RESET  = INIT_SWEEP ? ST_INIT : ST_RUN;

    logic          state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          write_q, write_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [15:0]   conf_q, conf_d;

    logic          run;
    logic          gnt0, gnt1;
    logic          wr_en;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // On contention the requester that did not win last time is served.
    assign run  = (state_q == ST_RUN);
    assign gnt0 = run && req0_valid && (!req1_valid || last_grant_q);
    assign gnt1 = run && req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        sel_addr = gnt1 ? req1_addr : req0_addr;
        sel_data = gnt1 ? req1_data : req0_data;
`ifdef REGFILE_ZERO_REG_EN
        wr_en = (gnt0 || gnt1) && (sel_addr != '0);
`else
        wr_en = gnt0 || gnt1;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        write_d      = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        conf_d       = conf_q;

        if (!run) begin
            write_d = 1'b1;
            waddr_d = cnt_q;
            wdata_d = '0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d = ST_RUN;
            end
        end else begin
            if (req0_valid && req1_valid && (conf_q != 16'hFFFF)) begin
                conf_d = conf_q + 16'd1;
            end
            if (gnt0 || gnt1) begin
                last_grant_d = gnt1;
            end
            // Address/data hold their last values when nothing is written.
            if (wr_en) begin
                write_d = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            conf_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            conf_q       <= conf_d;
        end
    end

    assign write        = write_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign init_done    = run;
    assign conflict_cnt = conf_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: sweep, arbitration, reset abort and random traffic
// against a rule-level reference model.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          r0, r1;
    logic          write;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic          init_done;
    logic [15:0]   conflict_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit            m_run;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_conf;
    logic [DW-1:0] rf [NREG];

    regfile_wb_arbiter #(.DW(DW), .AW(AW), .INIT_SWEEP(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0_valid   (v0),
        .req0_addr    (a0),
        .req0_data    (d0),
        .req0_ready   (r0),
        .req1_valid   (v1),
        .req1_addr    (a1),
        .req1_data    (d1),
        .req1_ready   (r1),
        .write        (write),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .init_done    (init_done),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_after_sweep();
        m_run  = 1'b1;
        m_last = 1;
        m_addr = AW'(NREG - 1);
        m_data = '0;
        m_conf = 0;
        for (int i = 0; i < NREG; i++) rf[i] = '0;
    endtask

    // One clock cycle: check readys against the arbitration rules, then the registered port.
    task automatic step(output int winner);
        bit exp_w;
        #1;
        winner = -1;
        if (m_run) begin
            if (v0 && v1) winner = (m_last == 1) ? 0 : 1;
            else if (v0)  winner = 0;
            else if (v1)  winner = 1;
        end
        n_vec++;
        if (r0 !== (winner == 0) || r1 !== (winner == 1)) begin
            n_err++;
            $display("FAIL ready: got r0=%b r1=%b, want r0=%b r1=%b", r0, r1,
                     winner == 0, winner == 1);
        end
        if (m_run && v0 && v1 && m_conf < 65535) m_conf++;
        exp_w = 1'b0;
        if (winner >= 0) begin
            m_last = winner;
`ifdef REGFILE_ZERO_REG_EN
            exp_w = ((winner == 0) ? a0 : a1) != '0;
`else
            exp_w = 1'b1;
`endif
            if (exp_w) begin
                m_addr = (winner == 0) ? a0 : a1;
                m_data = (winner == 0) ? d0 : d1;
            end
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (write !== exp_w || write_addr !== m_addr || write_data !== m_data) begin
            n_err++;
            $display("FAIL wport: got w=%b a=%0d d=%h, want w=%b a=%0d d=%h",
                     write, write_addr, write_data, exp_w, m_addr, m_data);
        end
        n_vec++;
        if (conflict_cnt !== 16'(m_conf) || init_done !== m_run) begin
            n_err++;
            $display("FAIL status: got conf=%0d done=%b, want conf=%0d done=%b",
                     conflict_cnt, init_done, m_conf, m_run);
        end
        if (write === 1'b1) rf[write_addr] = write_data;
    endtask

    // Sweep check with both requesters pushing; they must be held off throughout INIT.
    task automatic do_sweep(input int n);
        v0 = 1'b1; a0 = 5'd2; d0 = 32'hAAAA_0002;
        v1 = 1'b1; a1 = 5'd3; d1 = 32'hBBBB_0003;
        for (int i = 0; i < n; i++) begin
            #1;
            n_vec++;
            if (r0 !== 1'b0 || r1 !== 1'b0) begin
                n_err++;
                $display("FAIL sweep_ready[%0d]: got r0=%b r1=%b, want 0 0", i, r0, r1);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if (write !== 1'b1 || write_addr !== AW'(i) || write_data !== '0 ||
                init_done !== (i == NREG - 1) || conflict_cnt !== 16'd0) begin
                n_err++;
                $display("FAIL sweep[%0d]: got w=%b a=%0d d=%h done=%b conf=%0d, want 1 %0d 0 %b 0",
                         i, write, write_addr, write_data, init_done, conflict_cnt, i,
                         i == NREG - 1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (write !== 1'b0 || write_addr !== '0 || write_data !== '0 || init_done !== 1'b0 ||
            conflict_cnt !== 16'd0 || r0 !== 1'b0 || r1 !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got w=%b a=%0d d=%h done=%b conf=%0d r=%b%b, want all 0", tag,
                     write, write_addr, write_data, init_done, conflict_cnt, r0, r1);
        end
    endtask

    task automatic test_reset();
        int w;
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        do_sweep(NREG);
        model_after_sweep();
        // Both still valid on the first RUN cycle: req0 must win.
        step(w);
        v0 = 1'b0; v1 = 1'b0;
        step(w);
    endtask

    task automatic test_single();
        int w;
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEAD_BEEF;
        step(w);
        v0 = 1'b0;
        step(w);
    endtask

    task automatic test_contention();
        int w;
        logic [15:0] c_start;
        c_start = conflict_cnt;
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h0000_000A;
        v1 = 1'b1; a1 = 5'd4; d1 = 32'h0000_000B;
        repeat (4) step(w);
        v0 = 1'b0; v1 = 1'b0;
        step(w);
        n_vec++;
        if (conflict_cnt - c_start !== 16'd4) begin
            n_err++;
            $display("FAIL contention_cnt: got delta %0d, want 4", conflict_cnt - c_start);
        end
    endtask

    task automatic test_same_addr();
        int w;
        // Leave req1 as last grant so req0 is served first.
        v1 = 1'b1; a1 = 5'd9; d1 = 32'h99;
        step(w);
        v0 = 1'b1; a0 = 5'd7; d0 = 32'd1;
        v1 = 1'b1; a1 = 5'd7; d1 = 32'd2;
        step(w);
        if (w == 0) v0 = 1'b0;
        else v1 = 1'b0;
        step(w);
        v0 = 1'b0; v1 = 1'b0;
        step(w);
        n_vec++;
        if (rf[7] !== 32'd2) begin
            n_err++;
            $display("FAIL same_addr: got r7=%h, want 00000002", rf[7]);
        end
    endtask

    task automatic test_zero_reg();
        int w;
        v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
        step(w);
        v1 = 1'b0;
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h5678;
        step(w);
        v0 = 1'b0;
        step(w);
    endtask

    task automatic test_random();
        int w;
        bit hold0, hold1;
        hold0 = 1'b0; hold1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!hold0) begin
                v0 = ($urandom_range(0, 9) < 6);
                a0 = AW'($urandom);
                d0 = $urandom;
            end
            if (!hold1) begin
                v1 = ($urandom_range(0, 9) < 6);
                a1 = AW'($urandom);
                d1 = $urandom;
            end
            step(w);
            hold0 = v0 && (w != 0);
            hold1 = v1 && (w != 1);
        end
        v0 = 1'b0; v1 = 1'b0;
        step(w);
    endtask

    task automatic test_mid_reset();
        int w;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_run");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_sweep(10);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_sweep");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_sweep(NREG);
        model_after_sweep();
        v0 = 1'b0;
        step(w);
        v1 = 1'b0;
        step(w);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_same_addr();
        test_zero_reg();
        test_random();
        test_mid_reset();
        test_single();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
